// File: rtl/fft_pkg.sv
// Shared FFT datapath types and sizing helpers.
// Define BFLY_SCALE_EN for halved (WIDTH-bit) butterfly outputs.
package fft_pkg;

    localparam int NLANE = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        CALC,
        DRAIN
    } bfly_state_t;

    function automatic int cnt_w(input int d);
        return $clog2(2 * d);
    endfunction

    function automatic int ow_w(input int w);
`ifdef BFLY_SCALE_EN
        return w;
`else
        return w + 1;
`endif
    endfunction

endpackage

// File: rtl/bfly_stage_if.sv
// Butterfly stage stream bundle: current/delayed blocks in, results out.
interface bfly_stage_if
    import fft_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int OW    = ow_w(WIDTH)
) ();

    logic                        din_valid;
    logic [NLANE-1:0][WIDTH-1:0] din_real;
    logic [NLANE-1:0][WIDTH-1:0] din_imag;
    logic [NLANE-1:0][WIDTH-1:0] dly_real;
    logic [NLANE-1:0][WIDTH-1:0] dly_imag;
    logic                        dout_valid;
    logic                        dout_first;
    logic                        err;
    logic [NLANE-1:0][OW-1:0]    dout_real;
    logic [NLANE-1:0][OW-1:0]    dout_imag;

    modport master (
        output din_valid, din_real, din_imag, dly_real, dly_imag,
        input  dout_valid, dout_first, err, dout_real, dout_imag
    );

    modport slave (
        input  din_valid, din_real, din_imag, dly_real, dly_imag,
        output dout_valid, dout_first, err, dout_real, dout_imag
    );

endinterface

// File: rtl/bfly_diff_buf.sv
// Half-frame difference store: one shared index, registered read.
module bfly_diff_buf
    import fft_pkg::*;
#(
    parameter int  OW    = 10,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [AW-1:0]            idx,
    input  logic                     we,
    input  logic                     re,
    input  logic [NLANE-1:0][OW-1:0] wr_real,
    input  logic [NLANE-1:0][OW-1:0] wr_imag,
    output logic [NLANE-1:0][OW-1:0] rd_real,
    output logic [NLANE-1:0][OW-1:0] rd_imag
);

    logic [NLANE-1:0][OW-1:0] mem_re [DEPTH];
    logic [NLANE-1:0][OW-1:0] mem_im [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_re[idx] <= wr_real;
            mem_im[idx] <= wr_imag;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_real <= '0;
            rd_imag <= '0;
        end else if (re) begin
            rd_real <= mem_re[idx];
            rd_imag <= mem_im[idx];
        end
    end

endmodule

// File: rtl/bfly_stage.sv
// Radix-2 DIF butterfly stage: sums now, differences half a frame later.
// Define BFLY_SCALE_EN to round-half-up and halve every result.
module bfly_stage
    import fft_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int DELAY_LENGTH = 16
) (
    input logic         clk,
    input logic         rstn,
    bfly_stage_if.slave bus
);

    localparam int D  = DELAY_LENGTH;
    localparam int OW = ow_w(WIDTH);
    localparam int CW = cnt_w(D);
    localparam int AW = $clog2(D);

    bfly_state_t              state;
    logic [CW-1:0]            cnt;
    logic                     pend;
    logic                     vld_q, first_q, sel_q, err_q;
    logic                     we, re;
    logic [NLANE-1:0][OW-1:0] sum_re, sum_im, dif_re, dif_im;
    logic [NLANE-1:0][OW-1:0] sum_re_q, sum_im_q, rd_re, rd_im;

    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] a);
        return {a[WIDTH-1], a};
    endfunction

    function automatic logic [OW-1:0] fit(input logic [WIDTH:0] r);
`ifdef BFLY_SCALE_EN
        logic [WIDTH+1:0] t;
        t = {r[WIDTH], r} + (WIDTH+2)'(1);
        return t[WIDTH:1];
`else
        return r;
`endif
    endfunction

    always_comb begin
        for (int i = 0; i < NLANE; i++) begin
            sum_re[i] = fit(ext(bus.dly_real[i]) + ext(bus.din_real[i]));
            sum_im[i] = fit(ext(bus.dly_imag[i]) + ext(bus.din_imag[i]));
            dif_re[i] = fit(ext(bus.dly_real[i]) - ext(bus.din_real[i]));
            dif_im[i] = fit(ext(bus.dly_imag[i]) - ext(bus.din_imag[i]));
        end
    end

    // Writes only in CALC, reads only elsewhere, so one index suffices.
    always_comb begin
        we = 1'b0;
        re = 1'b0;
        case (state)
            IDLE:    re = pend;
            FILL:    re = pend && bus.din_valid;
            CALC:    we = bus.din_valid;
            DRAIN:   re = 1'b1;
            default: ;
        endcase
    end

    bfly_diff_buf #(
        .OW    (OW),
        .DEPTH (D)
    ) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .idx     (cnt[AW-1:0]),
        .we      (we),
        .re      (re),
        .wr_real (dif_re),
        .wr_imag (dif_im),
        .rd_real (rd_re),
        .rd_imag (rd_im)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            pend     <= 1'b0;
            vld_q    <= 1'b0;
            first_q  <= 1'b0;
            sel_q    <= 1'b0;
            err_q    <= 1'b0;
            sum_re_q <= '0;
            sum_im_q <= '0;
        end else begin
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            case (state)
                IDLE: begin
                    // Pending entry 0 leaves here, whether a frame starts or not.
                    vld_q <= pend;
                    sel_q <= 1'b1;
                    if (bus.din_valid) begin
                        state <= FILL;
                        cnt   <= CW'(1);
                    end else if (pend) begin
                        state <= DRAIN;
                        cnt   <= CW'(1);
                    end
                end
                FILL: begin
                    if (!bus.din_valid) begin
                        err_q <= 1'b1;
                        pend  <= 1'b0;
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        vld_q <= pend;
                        sel_q <= 1'b1;
                        cnt   <= cnt + CW'(1);
                        if (cnt == CW'(D - 1)) state <= CALC;
                    end
                end
                CALC: begin
                    if (!bus.din_valid) begin
                        err_q <= 1'b1;
                        pend  <= 1'b0;
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        vld_q    <= 1'b1;
                        sel_q    <= 1'b0;
                        first_q  <= (cnt == CW'(D));
                        sum_re_q <= sum_re;
                        sum_im_q <= sum_im;
                        if (cnt == CW'(2 * D - 1)) begin
                            state <= IDLE;
                            cnt   <= '0;
                            pend  <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    vld_q <= 1'b1;
                    sel_q <= 1'b1;
                    if (bus.din_valid) err_q <= 1'b1;
                    if (cnt == CW'(D - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        pend  <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dout_valid = vld_q;
    assign bus.dout_first = first_q;
    assign bus.err        = err_q;
    assign bus.dout_real  = sel_q ? rd_re : sum_re_q;
    assign bus.dout_imag  = sel_q ? rd_im : sum_im_q;

endmodule

// File: tb/tb_bfly_stage.sv
// Scoreboard bench for bfly_stage with a behavioural delay line.
module tb_bfly_stage;
    import fft_pkg::*;

    localparam int W = 9;
    localparam int D = 4;
`ifdef BFLY_SCALE_EN
    localparam int OW = W;
`else
    localparam int OW = W + 1;
`endif

    typedef logic [NLANE-1:0][W-1:0]  blk_t;
    typedef logic [NLANE-1:0][OW-1:0] oblk_t;
    typedef struct {
        oblk_t re;
        oblk_t im;
        logic  first;
    } exp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    bfly_stage_if #(.WIDTH(W), .OW(OW)) bus ();

    bfly_stage #(
        .WIDTH        (W),
        .DELAY_LENGTH (D)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sbq[$];
    int   lane0_log[$];
    int   run = 0, maxrun = 0, nvalid = 0;
    int   cyc = 0, first_cyc = -1;
    blk_t hre[D], him[D];

    task automatic chk(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] bfly_model(input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input bit sub);
        int x, y, s;
        x = $signed(a);
        y = $signed(b);
        s = sub ? x - y : x + y;
`ifdef BFLY_SCALE_EN
        s = (s + 1) >>> 1;
`endif
        return OW'(s);
    endfunction

    function automatic blk_t rnd();
        blk_t b;
        for (int l = 0; l < NLANE; l++) b[l] = W'($urandom);
        return b;
    endfunction

    // Inputs change 1 time unit after the edge; delay line shifts every clock.
    task automatic drive(input logic v, input blk_t r, input blk_t i);
        bus.din_valid = v;
        bus.din_real  = r;
        bus.din_imag  = i;
        bus.dly_real  = hre[D-1];
        bus.dly_imag  = him[D-1];
        @(posedge clk);
        for (int k = D - 1; k > 0; k--) begin
            hre[k] = hre[k-1];
            him[k] = him[k-1];
        end
        hre[0] = r;
        him[0] = i;
        #1;
    endtask

    task automatic frame(input blk_t r[2*D], input blk_t i[2*D], input int stop);
        exp_t e;
        for (int n = 0; n < 2 * D; n++) begin
            if (n == stop) return;
            if (n >= D) begin
                for (int l = 0; l < NLANE; l++) begin
                    e.re[l] = bfly_model(r[n-D][l], r[n][l], 1'b0);
                    e.im[l] = bfly_model(i[n-D][l], i[n][l], 1'b0);
                end
                e.first = (n == D);
                sbq.push_back(e);
            end
            drive(1'b1, r[n], i[n]);
        end
        for (int j = 0; j < D; j++) begin
            for (int l = 0; l < NLANE; l++) begin
                e.re[l] = bfly_model(r[j][l], r[j+D][l], 1'b1);
                e.im[l] = bfly_model(i[j][l], i[j+D][l], 1'b1);
            end
            e.first = 1'b0;
            sbq.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, '0, '0);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rstn && bus.dout_valid) begin
            run++;
            nvalid++;
            if (run > maxrun) maxrun = run;
            if (first_cyc < 0) first_cyc = cyc;
            lane0_log.push_back(int'($signed(bus.dout_real[0])));
            if (sbq.size() == 0) begin
                chk("unexpected_out", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("re_lane0", $signed(bus.dout_real[0]), $signed(e.re[0]));
                chk("re_vec", bus.dout_real === e.re, 1);
                chk("im_vec", bus.dout_imag === e.im, 1);
                chk("first", bus.dout_first, e.first);
            end
        end else begin
            run = 0;
        end
    end

`ifdef BFLY_SCALE_EN
    int t1_exp[8] = '{6, 11, 17, 22, 5, 9, 14, 18};
    int ext_sum   = 0;
    int ext_dif   = -255;
`else
    int t1_exp[8] = '{11, 22, 33, 44, 9, 18, 27, 36};
    int ext_sum   = -1;
    int ext_dif   = -511;
`endif

    initial begin
        blk_t fr[2*D], fi[2*D], gr[2*D], gi[2*D];
        int   c0, nv0;
        int   v1[2*D];
        v1 = '{10, 20, 30, 40, 1, 2, 3, 4};
        for (int k = 0; k < D; k++) begin
            hre[k] = '0;
            him[k] = '0;
        end
        bus.din_valid = 1'b0;
        bus.din_real  = '0;
        bus.din_imag  = '0;
        bus.dly_real  = '0;
        bus.dly_imag  = '0;

        idle(3);
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_first", bus.dout_first, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_data", (bus.dout_real == '0) && (bus.dout_imag == '0), 1);
        rstn = 1'b1;
        idle(2);

        // Single frame with known lane-0 values
        for (int n = 0; n < 2 * D; n++) begin
            fr[n]    = rnd();
            fr[n][0] = W'(v1[n]);
            fi[n]    = '0;
        end
        lane0_log.delete();
        maxrun = 0; first_cyc = -1; nv0 = nvalid; c0 = cyc;
        frame(fr, fi, 2 * D);
        idle(8);
        chk("t1_count", nvalid - nv0, 8);
        chk("t1_run", maxrun, 8);
        chk("t1_latency", first_cyc, c0 + D + 1);
        for (int k = 0; k < 8; k++)
            if (k < lane0_log.size()) chk("t1_lane0", lane0_log[k], t1_exp[k]);
            else chk("t1_lane0_missing", k, -1);
        chk("t1_sb_empty", sbq.size(), 0);

        // Full-scale extremes
        for (int n = 0; n < 2 * D; n++) begin
            fr[n] = rnd();
            fi[n] = rnd();
            fr[n][0] = (n < D) ? W'(-256) : W'(255);
        end
        lane0_log.delete();
        frame(fr, fi, 2 * D);
        idle(8);
        if (lane0_log.size() == 8) begin
            chk("ext_sum", lane0_log[0], ext_sum);
            chk("ext_dif", lane0_log[4], ext_dif);
        end else begin
            chk("ext_count", lane0_log.size(), 8);
        end
        chk("ext_sb_empty", sbq.size(), 0);

        // Two gapless frames
        for (int n = 0; n < 2 * D; n++) begin
            fr[n] = rnd(); fi[n] = rnd();
            gr[n] = rnd(); gi[n] = rnd();
        end
        maxrun = 0; nv0 = nvalid;
        frame(fr, fi, 2 * D);
        frame(gr, gi, 2 * D);
        idle(10);
        chk("b2b_count", nvalid - nv0, 16);
        chk("b2b_run", maxrun, 16);
        chk("b2b_sb_empty", sbq.size(), 0);

        // Valid pulse during drain
        chk("drain_err_before", bus.err, 0);
        nv0 = nvalid;
        frame(fr, fi, 2 * D);
        idle(1);
        drive(1'b1, rnd(), rnd());
        chk("drain_err", bus.err, 1);
        idle(8);
        chk("drain_count", nvalid - nv0, 8);
        chk("drain_sb_empty", sbq.size(), 0);

        // Reset asserted mid-CALC
        for (int n = 0; n < 2 * D; n++) begin
            fr[n] = rnd(); fi[n] = rnd();
        end
        frame(fr, fi, D + 2);
        #2;
        rstn = 1'b0;
        #1;
        sbq.delete();
        chk("mrst_valid", bus.dout_valid, 0);
        chk("mrst_err", bus.err, 0);
        chk("mrst_data", (bus.dout_real == '0) && (bus.dout_imag == '0), 1);
        idle(2);
        rstn = 1'b1;
        idle(2);
        nv0 = nvalid;
        frame(gr, gi, 2 * D);
        idle(8);
        chk("mrst_count", nvalid - nv0, 8);
        chk("mrst_sb_empty", sbq.size(), 0);

        // Valid dropped at cnt=5
        nv0 = nvalid;
        frame(fr, fi, 5);
        drive(1'b0, '0, '0);
        chk("drop_err", bus.err, 1);
        chk("drop_valid", bus.dout_valid, 0);
        idle(8);
        chk("drop_count", nvalid - nv0, 1);
        chk("drop_sb_empty", sbq.size(), 0);

        // Recovery frame after error
        nv0 = nvalid;
        frame(gr, gi, 2 * D);
        idle(8);
        chk("recov_count", nvalid - nv0, 8);
        chk("recov_err_sticky", bus.err, 1);
        chk("recov_sb_empty", sbq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
